// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module  : cpu_pkg
//  Purpose : Shared types and helpers for the 05_cpu memory stage.
//            - funct3 size/sign encodings for RV32 loads and stores
//            - load/store unit FSM state encoding
//            - access-size classification and alignment helpers
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  // Any funct3 that is not an explicit byte or half encoding (010, 011,
  // 110, 111) is handled as a full word access.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3_size(f3))
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
//  Module  : load_store_unit_if
//  Purpose : Valid/ready data-memory bus between the load/store unit and
//            data memory.
//  Signals : o_mem_valid  request valid            (master -> slave)
//            i_mem_ready  request accepted         (slave  -> master)
//            o_mem_addr   word-aligned byte address
//            o_mem_we     1 = write
//            o_mem_wstrb  byte-lane enables
//            o_mem_wdata  lane-positioned store data
//            i_mem_rvalid read data valid          (slave  -> master)
//            i_mem_rdata  read word
//  Modports: master (load/store unit), slave (memory)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) ();

  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic [3:0]        o_mem_wstrb;
  logic [WIDTH-1:0]  o_mem_wdata;
  logic              i_mem_rvalid;
  logic [WIDTH-1:0]  i_mem_rdata;

  modport master (
    output o_mem_valid, o_mem_addr, o_mem_we, o_mem_wstrb, o_mem_wdata,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_valid, o_mem_addr, o_mem_we, o_mem_wstrb, o_mem_wdata,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module  : lsu_align
//  Purpose : Combinational byte-lane steering for the load/store unit.
//            Stores: builds the byte strobe and replicates store data across
//            lanes. Loads: shifts the read word down by the byte offset and
//            sign- or zero-extends it.
//  Ports   : i_funct3  [2:0]  size/sign encoding
//            i_off     [1:0]  byte offset within the word
//            i_wdata   [31:0] right-aligned store data
//            i_rdata   [31:0] raw read word
//            o_wstrb   [3:0]  byte-lane enables (store)
//            o_wdata   [31:0] lane-positioned store data
//            o_rdata   [31:0] extended load data
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
  import cpu_pkg::*;
(
  input  wire logic [2:0]  i_funct3,
  input  wire logic [1:0]  i_off,
  input  wire logic [31:0] i_wdata,
  input  wire logic [31:0] i_rdata,
  output logic      [3:0]  o_wstrb,
  output logic      [31:0] o_wdata,
  output logic      [31:0] o_rdata
);

  lsu_size_t   size;
  logic [1:0]  eff_off;
  logic [31:0] rshift;

  always_comb begin
    size    = f3_size(i_funct3);
    // Misaligned offsets are rounded down to the natural boundary of the
    // access so a half never straddles lanes 1/2 and a word always uses all
    // four lanes.
    eff_off = i_off;
    case (size)
      SZ_HALF: eff_off = i_off & 2'b10;
      SZ_WORD: eff_off = 2'b00;
      default: eff_off = i_off;
    endcase

    rshift = i_rdata >> {eff_off, 3'b000};

    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = rshift;
    case (size)
      SZ_BYTE: begin
        o_wstrb = 4'b0001 << eff_off;
        o_wdata = {4{i_wdata[7:0]}};
        // funct3[2] distinguishes the unsigned variants (LBU/LHU).
        o_rdata = i_funct3[2] ? {24'h000000, rshift[7:0]}
                              : {{24{rshift[7]}}, rshift[7:0]};
      end
      SZ_HALF: begin
        o_wstrb = 4'b0011 << eff_off;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_funct3[2] ? {16'h0000, rshift[15:0]}
                              : {{16{rshift[15]}}, rshift[15:0]};
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = rshift;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module  : load_store_unit
//  Purpose : Memory stage of the 05_cpu core. Accepts one load/store request
//            from execute, runs it on the valid/ready data-memory bus and
//            returns extended load data to the writeback mux.
//  Params  : WIDTH  data width (32 only, four byte lanes)
//            ADDR_W byte-address width
//  Ports   : i_clk, i_rst_n          clock, async active-low reset
//            i_req, i_we, i_funct3,
//            i_addr, i_wdata         request from execute (sampled in IDLE)
//            o_busy                  pipeline stall (REQ/WAIT)
//            o_done                  one-cycle completion pulse
//            o_rdata                 extended load data, held between loads
//            mem                     data-memory bus (master modport)
//            o_misaligned            misalignment trap flag (macro only)
//  Config  : MISALIGN_TRAP_EN - when defined, misaligned half/word accesses
//            skip the bus and complete at once with o_misaligned=1. When
//            undefined, misaligned offsets are rounded down.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic              i_req,
  input  wire logic              i_we,
  input  wire logic [2:0]        i_funct3,
  input  wire logic [ADDR_W-1:0] i_addr,
  input  wire logic [WIDTH-1:0]  i_wdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic      [WIDTH-1:0]  o_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic                   o_misaligned,
`endif
  load_store_unit_if.master      mem
);

  lsu_state_t        state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;

  logic              mem_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  rdata_q;
`ifdef MISALIGN_TRAP_EN
  logic              misaligned_q;
`endif

  logic [3:0]        wstrb_w;
  logic [WIDTH-1:0]  wdata_sh;
  logic [WIDTH-1:0]  rdata_d;

  lsu_align u_align (
    .i_funct3 (funct3_q),
    .i_off    (addr_q[1:0]),
    .i_wdata  (wdata_q),
    .i_rdata  (mem.i_mem_rdata),
    .o_wstrb  (wstrb_w),
    .o_wdata  (wdata_sh),
    .o_rdata  (rdata_d)
  );

  // Bus fields come straight from the latched request, so they stay stable
  // for the whole REQ phase regardless of what execute does meanwhile.
  assign mem.o_mem_valid = mem_valid_q;
  assign mem.o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_wstrb = we_q ? wstrb_w : 4'b0000;
  assign mem.o_mem_wdata = wdata_sh;

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_rdata = rdata_q;
`ifdef MISALIGN_TRAP_EN
  assign o_misaligned = misaligned_q;
`endif

  // Single FSM process; every output flag is registered alongside the state
  // so it is glitch-free and changes exactly with the state transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req) begin
            we_q     <= i_we;
            funct3_q <= i_funct3;
            addr_q   <= i_addr;
            wdata_q  <= i_wdata;
`ifdef MISALIGN_TRAP_EN
            if (is_misaligned(i_funct3, i_addr[1:0])) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else begin
`else
            begin
`endif
              state_q     <= REQ;
              mem_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end

        REQ: begin
          if (mem.i_mem_ready) begin
            mem_valid_q <= 1'b0;
            if (we_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end

        WAIT: begin
          if (mem.i_mem_rvalid) begin
            rdata_q <= rdata_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          state_q      <= IDLE;
`ifdef MISALIGN_TRAP_EN
          misaligned_q <= 1'b0;
`endif
        end

        default: begin
          state_q     <= IDLE;
          mem_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
